// File: rtl/pcap_defs_pkg.sv
// pcap_defs: shared PCAP record header layout, limits and parser state encoding
package pcap_defs;

    localparam int PCAP_REC_HDR_BYTES = 16;
    localparam int OFF_SEC  = 0;
    localparam int OFF_NSEC = 4;
    localparam int OFF_INCL = 8;
    localparam int OFF_ORIG = 12;

    localparam logic [31:0] NSEC_PER_SEC = 32'd1_000_000_000;

    typedef enum logic [1:0] {
        HDR,
        HOLD,
        PAYLOAD,
        DROP
    } state_e;

    // Extract a little-endian 32-bit field starting at byte offset off
    function automatic logic [31:0] field32(input logic [127:0] h, input int off);
        return h[8*off +: 32];
    endfunction

endpackage

// File: rtl/axis_reg_slice8.sv
// axis_reg_slice8: single-stage byte-wide AXI-Stream register slice with tlast/tuser
module axis_reg_slice8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tuser,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser
);

    logic [9:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign s_tready = m_tready || !valid_q;
    assign m_tvalid = valid_q;
    assign {m_tuser, m_tlast, m_tdata} = data_q;

    // Load on an accepted input beat, otherwise empty once downstream takes the beat
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_tvalid && s_tready) begin
            valid_d = 1'b1;
            data_d  = {s_tuser, s_tlast, s_tdata};
        end else if (m_tready) begin
            valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pcap_record_parser.sv
// pcap_record_parser: strips/validates PCAP record headers and forwards the payload as AXI-Stream
module pcap_record_parser
    import pcap_defs::*;
#(
    parameter logic [31:0] MAX_LEN    = 32'd2048,
    parameter logic [31:0] NSEC_LIMIT = NSEC_PER_SEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic [31:0] m_hdr_sec,
    output logic [31:0] m_hdr_nsec,
    output logic [31:0] m_hdr_incl_len,
    output logic [31:0] m_hdr_orig_len,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        err_hdr,
    output logic        err_len
);

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    rem_q, rem_d;
    logic [127:0]   hdr_q, hdr_d;
    logic [31:0]    sec_q, sec_d, nsec_q, nsec_d, incl_q, incl_d, orig_q, orig_d;
    logic           hdr_valid_q, hdr_valid_d;
    logic           last15_q, last15_d;
    logic           uacc_q, uacc_d;
    logic           err_hdr_q, err_hdr_d;
    logic           err_len_q, err_len_d;
    logic           sl_valid, sl_ready, sl_last, sl_user, len_mis;

    assign m_hdr_valid    = hdr_valid_q;
    assign m_hdr_sec      = sec_q;
    assign m_hdr_nsec     = nsec_q;
    assign m_hdr_incl_len = incl_q;
    assign m_hdr_orig_len = orig_q;
    assign err_hdr        = err_hdr_q;
    assign err_len        = err_len_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            cnt_q       <= '0;
            rem_q       <= '0;
            hdr_q       <= '0;
            sec_q       <= '0;
            nsec_q      <= '0;
            incl_q      <= '0;
            orig_q      <= '0;
            hdr_valid_q <= 1'b0;
            last15_q    <= 1'b0;
            uacc_q      <= 1'b0;
            err_hdr_q   <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            hdr_q       <= hdr_d;
            sec_q       <= sec_d;
            nsec_q      <= nsec_d;
            incl_q      <= incl_d;
            orig_q      <= orig_d;
            hdr_valid_q <= hdr_valid_d;
            last15_q    <= last15_d;
            uacc_q      <= uacc_d;
            err_hdr_q   <= err_hdr_d;
            err_len_q   <= err_len_d;
        end
    end

    // Next state: header assembly and checks, header handshake, payload length tracking, drop
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        hdr_d       = hdr_q;
        sec_d       = sec_q;
        nsec_d      = nsec_q;
        incl_d      = incl_q;
        orig_d      = orig_q;
        hdr_valid_d = hdr_valid_q;
        last15_d    = last15_q;
        uacc_d      = uacc_q;
        err_hdr_d   = 1'b0;
        err_len_d   = 1'b0;
        case (state_q)
            HDR: if (s_axis_tvalid) begin
                hdr_d = {s_axis_tdata, hdr_q[127:8]};
                if (cnt_q == 16'(PCAP_REC_HDR_BYTES - 1)) begin
                    cnt_d = '0;
                    if (field32(hdr_d, OFF_NSEC) < NSEC_LIMIT && field32(hdr_d, OFF_INCL) <= MAX_LEN) begin
                        state_d     = HOLD;
                        hdr_valid_d = 1'b1;
                        last15_d    = s_axis_tlast;
                        sec_d       = field32(hdr_d, OFF_SEC);
                        nsec_d      = field32(hdr_d, OFF_NSEC);
                        incl_d      = field32(hdr_d, OFF_INCL);
                        orig_d      = field32(hdr_d, OFF_ORIG);
                    end else begin
                        err_hdr_d = 1'b1;
                        state_d   = s_axis_tlast ? HDR : DROP;
                    end
                end else if (s_axis_tlast) begin
                    err_hdr_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: if (m_hdr_ready) begin
                hdr_valid_d = 1'b0;
                uacc_d      = 1'b0;
                rem_d       = incl_q[15:0];
                // A zero-length record must end on byte 15; a non-empty one must not
                err_len_d   = (incl_q == '0) != last15_q;
                state_d     = last15_q ? HDR : (incl_q == '0) ? DROP : PAYLOAD;
            end
            PAYLOAD: if (sl_valid && sl_ready) begin
                rem_d  = rem_q - 16'd1;
                uacc_d = uacc_q || s_axis_tuser;
                if (sl_last) begin
                    err_len_d = len_mis;
                    state_d   = (rem_q == 16'd1 && !s_axis_tlast) ? DROP : HDR;
                end
            end
            DROP: if (s_axis_tvalid && s_axis_tlast) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    // Outputs: input ready per state and the beat offered to the output slice
    always_comb begin
        len_mis       = (rem_q == 16'd1) != s_axis_tlast;
        sl_valid      = state_q == PAYLOAD && s_axis_tvalid;
        sl_last       = rem_q == 16'd1 || s_axis_tlast;
        sl_user       = s_axis_tuser || uacc_q || (sl_last && len_mis);
        s_axis_tready = !rst && (state_q == PAYLOAD ? sl_ready : state_q != HOLD);
    end

    axis_reg_slice8 u_out (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_axis_tdata),
        .s_tvalid (sl_valid),
        .s_tready (sl_ready),
        .s_tlast  (sl_last),
        .s_tuser  (sl_user),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser)
    );

endmodule

// File: tb/tb_pcap_record_parser.sv
// tb_pcap_record_parser: randomized frame-level scoreboard bench for pcap_record_parser
module tb_pcap_record_parser;

    typedef struct packed {
        logic [31:0] orig;
        logic [31:0] incl;
        logic [31:0] nsec;
        logic [31:0] sec;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        m_hdr_valid;
    logic        m_hdr_ready = 1'b1;
    logic [31:0] m_hdr_sec, m_hdr_nsec, m_hdr_incl_len, m_hdr_orig_len;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        err_hdr;
    logic        err_len;

    int n_checks = 0;
    int n_fail = 0;
    bit bp = 0;
    bit hold_hdr = 0;

    logic [9:0] stim[$];
    logic [7:0] fb[$];
    logic       fu[$];
    hdr_t       exp_hdr[$], cap_hdr[$];
    logic [9:0] exp_beat[$], cap_beat[$];
    int e_hdr, e_len, c_hdr, c_len, stab_viol;
    logic  prev_hv = 0, prev_hs = 0;
    hdr_t  prev_f;

    pcap_record_parser dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_hdr_sec(m_hdr_sec), .m_hdr_nsec(m_hdr_nsec),
        .m_hdr_incl_len(m_hdr_incl_len), .m_hdr_orig_len(m_hdr_orig_len),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .err_hdr(err_hdr), .err_len(err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
        m_hdr_ready   = hold_hdr ? 1'b0 : bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) cap_beat.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (m_hdr_valid && m_hdr_ready) cap_hdr.push_back({m_hdr_orig_len, m_hdr_incl_len, m_hdr_nsec, m_hdr_sec});
            if (err_hdr) c_hdr++;
            if (err_len) c_len++;
            if (prev_hv && m_hdr_valid && !prev_hs &&
                {m_hdr_orig_len, m_hdr_incl_len, m_hdr_nsec, m_hdr_sec} != prev_f) stab_viol++;
            prev_hv = m_hdr_valid;
            prev_hs = m_hdr_valid && m_hdr_ready;
            prev_f  = {m_hdr_orig_len, m_hdr_incl_len, m_hdr_nsec, m_hdr_sec};
        end
    end

    task automatic clear_sb();
        stim.delete(); fb.delete(); fu.delete();
        exp_hdr.delete(); cap_hdr.delete(); exp_beat.delete(); cap_beat.delete();
        e_hdr = 0; e_len = 0; c_hdr = 0; c_len = 0; stab_viol = 0;
    endtask

    task automatic build_hdr(input logic [31:0] sec, input logic [31:0] nsec,
                             input logic [31:0] incl, input logic [31:0] orig);
        logic [31:0] v[4];
        v = '{sec, nsec, incl, orig};
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++) begin
                fb.push_back(v[k][8*b +: 8]);
                fu.push_back(1'b0);
            end
    endtask

    task automatic add_pay(input logic [7:0] d, input logic u);
        fb.push_back(d);
        fu.push_back(u);
    endtask

    // Frame-level reference: what a whole record should produce downstream
    task automatic commit_frame();
        int n, p, k;
        logic [31:0] f[4];
        logic acc;
        n = fb.size();
        for (int i = 0; i < n; i++) stim.push_back({fu[i], (i == n - 1), fb[i]});
        if (n < 16) begin
            e_hdr++;
        end else begin
            for (int j = 0; j < 4; j++) f[j] = {fb[4*j+3], fb[4*j+2], fb[4*j+1], fb[4*j]};
            if (f[1] >= 32'd1_000_000_000 || f[2] > 32'd2048) begin
                e_hdr++;
            end else begin
                exp_hdr.push_back({f[3], f[2], f[1], f[0]});
                p = n - 16;
                if (p != int'(f[2])) e_len++;
                k = (int'(f[2]) < p) ? int'(f[2]) : p;
                acc = 1'b0;
                for (int i = 0; i < k; i++) begin
                    acc = acc | fu[16+i];
                    exp_beat.push_back({acc | (i == k - 1 && p != int'(f[2])), (i == k - 1), fb[16+i]});
                end
            end
        end
        fb.delete();
        fu.delete();
    endtask

    task automatic drive_all();
        bit ok;
        int t;
        @(posedge clk);
        #1;
        foreach (stim[i]) begin
            if (bp && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            {s_axis_tuser, s_axis_tlast, s_axis_tdata} = stim[i];
            s_axis_tvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk);
                #1;
                t++;
            end while (!ok && t < 2000);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL input_stall: byte %0d not accepted, got tready=0 required 1", i);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        for (int t2 = 0; t2 < 3000; t2++) begin
            @(negedge clk);
            if (cap_beat.size() >= exp_beat.size() && cap_hdr.size() >= exp_hdr.size()) break;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b required 0", s_axis_tready); end
        n_checks++;
        if ({m_hdr_valid, m_axis_tvalid, err_hdr, err_len} !== 4'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b required 0000", {m_hdr_valid, m_axis_tvalid, err_hdr, err_len});
        end
        n_checks++;
        if ({m_hdr_sec, m_hdr_nsec, m_hdr_incl_len, m_hdr_orig_len} !== 128'b0) begin
            n_fail++; $display("FAIL reset_fields: got %h required 0", {m_hdr_sec, m_hdr_nsec, m_hdr_incl_len, m_hdr_orig_len});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b required 1", s_axis_tready); end
    endtask

    task automatic test_basic();
        clear_sb();
        build_hdr(32'd5, 32'd999_999_996, 32'd4, 32'd4);
        add_pay(8'hAA, 0); add_pay(8'hBB, 0); add_pay(8'hCC, 0); add_pay(8'hDD, 0);
        commit_frame();
        drive_all();
        n_checks++;
        if (cap_hdr.size() !== 1 || cap_hdr[0].sec !== 32'd5 || cap_hdr[0].nsec !== 32'd999_999_996 || cap_hdr[0].incl !== 32'd4) begin
            n_fail++; $display("FAIL basic_hdr: got count %0d first %h required 1 sec=5 nsec=999999996 incl=4",
                               cap_hdr.size(), cap_hdr.size() ? cap_hdr[0] : '0);
        end
        n_checks++;
        if (cap_beat.size() !== 4) begin n_fail++; $display("FAIL basic_beats: got %0d required 4", cap_beat.size()); end
        for (int i = 0; i < cap_beat.size() && i < exp_beat.size(); i++) begin
            n_checks++;
            if (cap_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL basic_beat[%0d]: got %h required %h", i, cap_beat[i], exp_beat[i]); end
        end
        n_checks++;
        if (c_hdr !== 0 || c_len !== 0) begin n_fail++; $display("FAIL basic_err: got hdr=%0d len=%0d required 0 0", c_hdr, c_len); end
    endtask

    task automatic test_zero_len();
        clear_sb();
        build_hdr(32'd7, 32'd123, 32'd0, 32'd60);
        commit_frame();
        build_hdr(32'd8, 32'd456, 32'd3, 32'd3);
        for (int i = 0; i < 3; i++) add_pay(8'($urandom), 0);
        commit_frame();
        drive_all();
        n_checks++;
        if (cap_hdr.size() !== 2) begin n_fail++; $display("FAIL zero_hdr_count: got %0d required 2", cap_hdr.size()); end
        for (int i = 0; i < cap_hdr.size() && i < exp_hdr.size(); i++) begin
            n_checks++;
            if (cap_hdr[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL zero_hdr[%0d]: got %h required %h", i, cap_hdr[i], exp_hdr[i]); end
        end
        n_checks++;
        if (cap_beat.size() !== 3) begin n_fail++; $display("FAIL zero_beats: got %0d required 3", cap_beat.size()); end
        for (int i = 0; i < cap_beat.size() && i < exp_beat.size(); i++) begin
            n_checks++;
            if (cap_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL zero_beat[%0d]: got %h required %h", i, cap_beat[i], exp_beat[i]); end
        end
        n_checks++;
        if (c_hdr !== 0 || c_len !== 0) begin n_fail++; $display("FAIL zero_err: got hdr=%0d len=%0d required 0 0", c_hdr, c_len); end
    endtask

    task automatic test_bad_nsec();
        clear_sb();
        build_hdr(32'd1, 32'd1_000_000_000, 32'd8, 32'd8);
        for (int i = 0; i < 8; i++) add_pay(8'($urandom), 0);
        commit_frame();
        build_hdr(32'd2, 32'd999_999_999, 32'd2, 32'd2);
        add_pay(8'h11, 0); add_pay(8'h22, 0);
        commit_frame();
        drive_all();
        n_checks++;
        if (c_hdr !== 1 || c_hdr !== e_hdr) begin n_fail++; $display("FAIL nsec_err_hdr: got %0d required 1", c_hdr); end
        n_checks++;
        if (cap_hdr.size() !== 1 || cap_hdr[0] !== exp_hdr[0]) begin
            n_fail++; $display("FAIL nsec_hdr: got count %0d first %h required 1 %h", cap_hdr.size(), cap_hdr.size() ? cap_hdr[0] : '0, exp_hdr[0]);
        end
        n_checks++;
        if (cap_beat.size() !== 2) begin n_fail++; $display("FAIL nsec_beats: got %0d required 2", cap_beat.size()); end
        for (int i = 0; i < cap_beat.size() && i < exp_beat.size(); i++) begin
            n_checks++;
            if (cap_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL nsec_beat[%0d]: got %h required %h", i, cap_beat[i], exp_beat[i]); end
        end
    endtask

    task automatic test_truncated();
        clear_sb();
        build_hdr(32'd3, 32'd10, 32'd6, 32'd6);
        for (int i = 0; i < 3; i++) add_pay(8'($urandom), 0);
        commit_frame();
        drive_all();
        n_checks++;
        if (cap_beat.size() !== 3) begin n_fail++; $display("FAIL trunc_beats: got %0d required 3", cap_beat.size()); end
        n_checks++;
        if (cap_beat.size() == 3 && cap_beat[2][9:8] !== 2'b11) begin n_fail++; $display("FAIL trunc_last: got user,last=%b required 11", cap_beat[2][9:8]); end
        for (int i = 0; i < cap_beat.size() && i < exp_beat.size(); i++) begin
            n_checks++;
            if (cap_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL trunc_beat[%0d]: got %h required %h", i, cap_beat[i], exp_beat[i]); end
        end
        n_checks++;
        if (c_len !== 1 || c_hdr !== 0) begin n_fail++; $display("FAIL trunc_err: got hdr=%0d len=%0d required 0 1", c_hdr, c_len); end
    endtask

    task automatic test_overlong();
        clear_sb();
        build_hdr(32'd4, 32'd20, 32'd2, 32'd5);
        for (int i = 0; i < 5; i++) add_pay(8'($urandom), 0);
        commit_frame();
        build_hdr(32'd9, 32'd30, 32'd1, 32'd1);
        add_pay(8'h5A, 0);
        commit_frame();
        drive_all();
        n_checks++;
        if (cap_beat.size() !== 3) begin n_fail++; $display("FAIL long_beats: got %0d required 3", cap_beat.size()); end
        n_checks++;
        if (cap_beat.size() >= 2 && cap_beat[1][9:8] !== 2'b11) begin n_fail++; $display("FAIL long_last: got user,last=%b required 11", cap_beat[1][9:8]); end
        for (int i = 0; i < cap_beat.size() && i < exp_beat.size(); i++) begin
            n_checks++;
            if (cap_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL long_beat[%0d]: got %h required %h", i, cap_beat[i], exp_beat[i]); end
        end
        n_checks++;
        if (c_len !== 1 || cap_hdr.size() !== 2) begin n_fail++; $display("FAIL long_err: got len=%0d hdrs=%0d required 1 2", c_len, cap_hdr.size()); end
    endtask

    task automatic test_backpressure();
        int incl;
        clear_sb();
        bp = 1;
        for (int f = 0; f < 12; f++) begin
            if (f == 5) begin
                for (int i = 0; i < 10; i++) add_pay(8'($urandom), 0);
            end else begin
                incl = $urandom_range(0, 12);
                build_hdr($urandom, $urandom_range(0, 999_999_999), incl, $urandom_range(incl, 1500));
                for (int i = 0; i < incl; i++) add_pay(8'($urandom), $urandom_range(0, 9) == 0);
            end
            commit_frame();
        end
        drive_all();
        bp = 0;
        n_checks++;
        if (cap_hdr.size() !== exp_hdr.size()) begin n_fail++; $display("FAIL bp_hdr_count: got %0d required %0d", cap_hdr.size(), exp_hdr.size()); end
        for (int i = 0; i < cap_hdr.size() && i < exp_hdr.size(); i++) begin
            n_checks++;
            if (cap_hdr[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL bp_hdr[%0d]: got %h required %h", i, cap_hdr[i], exp_hdr[i]); end
        end
        n_checks++;
        if (cap_beat.size() !== exp_beat.size()) begin n_fail++; $display("FAIL bp_beat_count: got %0d required %0d", cap_beat.size(), exp_beat.size()); end
        for (int i = 0; i < cap_beat.size() && i < exp_beat.size(); i++) begin
            n_checks++;
            if (cap_beat[i] !== exp_beat[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h required %h", i, cap_beat[i], exp_beat[i]); end
        end
        n_checks++;
        if (c_hdr !== e_hdr || c_len !== e_len) begin n_fail++; $display("FAIL bp_err: got hdr=%0d len=%0d required %0d %0d", c_hdr, c_len, e_hdr, e_len); end
        n_checks++;
        if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_hdr_stable: got %0d changes required 0", stab_viol); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        hold_hdr = 1;
        build_hdr(32'd1, 32'd2, 32'd4, 32'd4);
        foreach (fb[i]) stim.push_back({1'b0, 1'b0, fb[i]});
        fb.delete(); fu.delete();
        drive_all();
        n_checks++;
        if (m_hdr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_hdr_pending: got %b required 1", m_hdr_valid); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_hdr_valid, m_axis_tvalid, s_axis_tready} !== 3'b0) begin
            n_fail++; $display("FAIL mid_reset: got hv,mv,rdy=%b required 000", {m_hdr_valid, m_axis_tvalid, s_axis_tready});
        end
        rst = 1'b0;
        hold_hdr = 0;
        @(negedge clk);
        n_checks++;
        if (s_axis_tready !== 1'b1 || m_hdr_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_recover: got rdy=%b hv=%b required 1 0", s_axis_tready, m_hdr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_bad_nsec();
        test_truncated();
        test_overlong();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcap_record_parser.md
Name: pcap_record_parser

Overview:
- Consumes a byte-wide AXI-Stream of PCAP records, one record per frame: a 16-byte little-endian record header (ts_sec, ts_nsec, incl_len, orig_len) followed by incl_len payload bytes.
- Strips and validates the header, presents the decoded timestamp and lengths on a separate header handshake, then forwards the payload as a clean AXI-Stream frame.
- Sits on the replay/readback path and is the decoding counterpart of the nanosecond PCAP timestamp and record-header generation on capture.

Parameters:
- MAX_LEN, 2048, largest accepted incl_len in bytes; larger values are a header error.
- NSEC_LIMIT, 1_000_000_000, ts_nsec must be strictly below this value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  record byte stream
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  end of record
- s_axis_tuser  in  1  upstream error, OR-ed into output tuser
- m_hdr_valid  out  1  decoded header available
- m_hdr_ready  in  1
- m_hdr_sec  out  32
- m_hdr_nsec  out  32
- m_hdr_incl_len  out  32
- m_hdr_orig_len  out  32
- m_axis_tdata  out  8  payload bytes
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser  out  1  bad/truncated frame
- err_hdr  out  1  one-cycle pulse: runt header, incl_len > MAX_LEN, or ts_nsec >= NSEC_LIMIT
- err_len  out  1  one-cycle pulse: tlast position disagrees with incl_len

Behaviour:
- Reset values: all valid and pulse outputs 0; header fields 0; state HDR; byte counter 0; s_axis_tready 0 during reset.
- Transfers occur only on the cycle where valid and ready are both high.
- HDR state:
  - s_axis_tready = 1. Bytes 0-15 are shifted into a 128-bit header register in little-endian order per field.
  - On byte 15, check the fields. If valid, go to HOLD with m_hdr_valid = 1 on the next cycle. If invalid, pulse err_hdr and go to DROP, or straight back to HDR if byte 15 carried tlast.
  - tlast on bytes 0-14 is a runt: pulse err_hdr, stay in HDR, counter = 0, no header emitted.
- HOLD state:
  - s_axis_tready = 0. Header fields stay stable while m_hdr_valid is high.
  - On the m_hdr_ready handshake, go to PAYLOAD with remaining = incl_len.
  - If incl_len = 0 and byte 15 had tlast, go to HDR instead.
  - If incl_len = 0 and byte 15 lacked tlast, pulse err_len and go to DROP.
- PAYLOAD state:
  - Single output register stage, 1-cycle latency.
  - s_axis_tready = m_axis_tready || !m_axis_tvalid. Each accepted byte decrements remaining.
  - Byte with remaining = 1 and tlast: output tlast = 1, tuser = s_tuser, go to HDR.
  - Byte with remaining = 1 without tlast: output tlast = 1, tuser = 1, pulse err_len, go to DROP.
  - tlast with remaining > 1 (truncated): output tlast = 1, tuser = 1, pulse err_len, go to HDR.
- DROP state: s_axis_tready = 1. Discard bytes until one with tlast is accepted, then go to HDR. Nothing is emitted.
- Width: remaining and the byte counter are 16 bits. incl_len is compared as a full 32-bit value, so upper bits being set is a header error.
- Header outputs are held until the next valid header is latched. The pending m_axis output beat drains independently of the state change.
- Reset mid-record: abandon immediately and drop m_axis_tvalid and m_hdr_valid with no tlast. The downstream owns recovery.
- Output tuser is 1 whenever any s_tuser in the payload was 1, or the frame ended by error.

Decomposition:
- Shared package/header pcap_defs:
  - PCAP_REC_HDR_BYTES = 16 and field byte offsets (0, 4, 8, 12).
  - NSEC_PER_SEC = 1_000_000_000.
  - State encodings HDR, HOLD, PAYLOAD, DROP.
- One sub-module, axis_reg_slice8: the single-stage output register with ready/valid, reusable elsewhere. All other logic stays in the top module.

Test Plan:
- Header sec = 0x00000005, nsec = 999_999_996, incl = orig = 4, payload AA BB CC DD with tlast on DD -> m_hdr sec = 5, nsec = 999999996, incl = 4; m_axis AA..DD with tlast on DD, tuser = 0; no error pulses.
- incl = 0 with tlast on byte 15 -> one header emitted, no m_axis beat, parser back in HDR; a second back-to-back record parses correctly.
- nsec = 1_000_000_000 with 8 payload bytes -> err_hdr pulses once, no header, all 8 bytes dropped; the next record parses.
- incl = 6, tlast after 3 payload bytes -> 3 bytes out, third with tlast = 1 and tuser = 1; err_len pulses once.
- incl = 2 but frame carries 5 payload bytes -> 2 bytes out, tlast on 2nd with tuser = 1; err_len pulses; 3 bytes dropped.
- Random m_axis_tready and m_hdr_ready backpressure at 30% plus a 10-byte runt frame -> no byte lost or duplicated, err_hdr pulses for the runt, and header fields stay stable while m_hdr_valid is high.
